// File: rtl/alu32_sliced_reg_if.sv
// Operand/control and registered-result bundle for the sliced ALU stage.
// The master drives operands; the slave (ALU) returns the registered result and flags.
interface alu32_sliced_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;

  modport master (
    output in_valid, a, b, ctrl,
    input  result, zero, overflow, carry_out, carry_vec, out_valid
  );

  modport slave (
    input  in_valid, a, b, ctrl,
    output result, zero, overflow, carry_out, carry_vec, out_valid
  );
endinterface

// File: rtl/alu32_sliced_reg.sv
// Registered MIPS-style ALU: WIDTH ripple-carry 1-bit slices, an SLT result mux,
// and a single register stage for result, flags and valid.
module alu32_sliced_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu32_sliced_reg_if.slave   bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;

  logic             binv_c;
  logic             arith_c;
  logic             carry_c;
  logic [1:0]       slice_c;
  logic [WIDTH-1:0] slice_res_c;
  logic [WIDTH-1:0] chain_c;
  logic             ovf_c;
  logic             less_c;
  logic [WIDTH-1:0] final_c;

  // One ALU slice: returns {carry_out, result_bit}.
  function automatic logic [1:0] slice_f(input logic ai, input logic bi,
                                         input logic binv, input logic ci,
                                         input logic [2:0] op);
    logic bb;
    logic r;
    bb = bi ^ binv;
    case (op)
      OP_XOR:  r = ai ^ bi;
      OP_AND:  r = ai & bi;
      OP_NAND: r = ~(ai & bi);
      OP_NOR:  r = ~(ai | bi);
      OP_ADD, OP_SUB, OP_SLT: r = ai ^ bb ^ ci;
      default: r = ai | bi;
    endcase
    return {(ai & bb) | (ci & (ai ^ bb)), r};
  endfunction

  // Ripple the carry through the slices; the raw chain is masked later for logic ops.
  always_comb begin
    binv_c      = (bus.ctrl == OP_SUB) || (bus.ctrl == OP_SLT);
    arith_c     = (bus.ctrl == OP_ADD) || binv_c;
    carry_c     = ~bus.ctrl[2] & bus.ctrl[0];
    slice_c     = 2'b00;
    slice_res_c = '0;
    chain_c     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      slice_c        = slice_f(bus.a[i], bus.b[i], binv_c, carry_c, bus.ctrl);
      slice_res_c[i] = slice_c[0];
      chain_c[i]     = slice_c[1];
      carry_c        = slice_c[1];
    end
  end

  // Signed less-than stays correct on overflow by folding the overflow into the sign bit.
  always_comb begin
    ovf_c   = chain_c[WIDTH-1] ^ chain_c[WIDTH-2];
    less_c  = slice_res_c[WIDTH-1] ^ ovf_c;
    final_c = (bus.ctrl == OP_SLT) ? WIDTH'(less_c) : slice_res_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.carry_vec <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result    <= final_c;
        bus.zero      <= (final_c == '0);
        bus.overflow  <= arith_c & ovf_c;
        bus.carry_out <= arith_c & chain_c[WIDTH-1];
        bus.carry_vec <= arith_c ? chain_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_alu32_sliced_reg.sv
// Directed self-checking bench for alu32_sliced_reg: vector table plus
// reset, valid-gating, mid-stream reset and back-to-back sequences.
module tb_alu32_sliced_reg;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu32_sliced_reg_if #(.WIDTH(32)) bus ();

  alu32_sliced_reg #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic [31:0] cv;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.ctrl     = c;
  endtask

  task automatic check_all(input string n, input logic [31:0] res, input logic z, input logic o,
                           input logic co, input logic [31:0] cv, input logic ov);
    check({n, ".result"},    bus.result, res);
    check({n, ".zero"},      32'(bus.zero), 32'(z));
    check({n, ".overflow"},  32'(bus.overflow), 32'(o));
    check({n, ".carry_out"}, 32'(bus.carry_out), 32'(co));
    check({n, ".carry_vec"}, bus.carry_vec, cv);
    check({n, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"slt_2_5",    32'd2,          32'd5,          3'b011, 32'd1,          1'b0, 1'b0, 1'b0, 32'h0000_0002});
    vecs.push_back('{"slt_5_2",    32'd5,          32'd2,          3'b011, 32'd0,          1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD});
    vecs.push_back('{"slt_min_1",  32'h8000_0000,  32'd1,          3'b011, 32'd1,          1'b0, 1'b1, 1'b1, 32'h8000_0000});
    vecs.push_back('{"add_ovf",    32'h7FFF_FFFF,  32'd1,          3'b000, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF});
    vecs.push_back('{"add_wrap",   32'hFFFF_FFFF,  32'd1,          3'b000, 32'd0,          1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{"sub_eq",     32'd5,          32'd5,          3'b001, 32'd0,          1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{"sub_neg",    32'd3,          32'd5,          3'b001, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 32'h0000_0003});
    vecs.push_back('{"xor",        32'hF0F0_1234,  32'hFF00_00FF,  3'b010, 32'h0FF0_12CB,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"and",        32'hF0F0_1234,  32'hFF00_00FF,  3'b100, 32'hF000_0034,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"nand",       32'hF0F0_1234,  32'hFF00_00FF,  3'b101, 32'h0FFF_FFCB,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"nor",        32'hF0F0_1234,  32'hFF00_00FF,  3'b110, 32'h000F_ED00,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"or",         32'hF0F0_1234,  32'hFF00_00FF,  3'b111, 32'hFFF0_12FF,  1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"and_zero",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b101, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0});

    // Reset held two cycles with a live operation presented.
    rst = 1'b1;
    drive(1'b1, 32'd3, 32'd4, 3'b000);
    step();
    check_all("rst1", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    check_all("rst2", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_rst", 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      step();
      check_all(vecs[i].name, vecs[i].res, vecs[i].zero, vecs[i].ovf, vecs[i].cout, vecs[i].cv, 1'b1);
    end

    // Valid gating: hold last result while in_valid is low.
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000);
    step();
    check_all("gate_op", 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'(k * 17 + 1), 32'(k + 9), 3'(k + 1));
      step();
      check_all($sformatf("gate_hold%0d", k), 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    end

    // Back-to-back ops, one result per cycle.
    drive(1'b1, 32'd1, 32'd1, 3'b000);
    step();
    check_all("b2b_add", 32'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
    drive(1'b1, 32'd9, 32'd4, 3'b001);
    step();
    check_all("b2b_sub", 32'd5, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b1);
    drive(1'b1, 32'd6, 32'd3, 3'b010);
    step();
    check_all("b2b_xor", 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset mid-stream discards the operation captured on that edge.
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b000);
    rst = 1'b1;
    step();
    check_all("mid_rst", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 32'd10, 32'd3, 3'b111);
    step();
    check_all("after_mid_rst", 32'd11, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    drive(1'b0, 32'd0, 32'd0, 3'b000);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu32_sliced_reg.md
Name: alu32_sliced_reg

Overview:
- Registered 32-bit MIPS-style ALU built from WIDTH identical 1-bit slices, followed by a per-bit 2:1 result mux for set-less-than.
- Each slice combines one bit of A and B with a ripple carry and produces a result bit and a carry out.
- Inputs are captured and computed combinationally; result and flags are registered, giving a single-cycle-latency datapath stage.
- Sits in the execute stage of the CPU datapath.

Parameters:
- WIDTH, 32, operand and result width in bits; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and ctrl valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ctrl  input  3  operation select.
- result  output  WIDTH  registered final result.
- zero  output  1  registered; 1 when result == 0.
- overflow  output  1  registered signed-overflow flag.
- carry_out  output  1  registered carry out of the MSB slice.
- carry_vec  output  WIDTH  registered per-slice carry outs; bit i is the carry out of slice i.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- ctrl encoding:
  - 000 ADD: a+b.
  - 001 SUB: a-b, computed as a + ~b + 1.
  - 010 XOR.
  - 011 SLT: signed a<b.
  - 100 AND.
  - 101 NAND.
  - 110 NOR.
  - 111 OR.
- Carry chain: carry-in of slice 0 = ctrl[0] when ctrl[2]=0; B is inverted into the slices when ctrl[2:0] is 001 or 011; slice i carry-in = carry_vec[i-1].
- Slice output: sum bit for ADD/SUB/SLT; bitwise function for XOR/AND/NAND/NOR/OR.
- Logic ops (010 and 1xx): carry_vec, carry_out and overflow are forced to 0.
- overflow = carry_vec[WIDTH-2] XOR carry_vec[WIDTH-1] for ADD, SUB and SLT.
- SLT: the final mux selects {WIDTH-1 zeros, less} where less = diff[WIDTH-1] XOR overflow of the subtraction. This is correct signed compare even on overflow. The overflow output for SLT is still reported as the subtraction's overflow.
- zero is computed on the final muxed result, not the pre-mux slice outputs.
- carry_out = carry_vec[WIDTH-1].
- Latency: values presented with in_valid=1 at edge N appear on result/flags after edge N; out_valid=1 in the same cycle.
- in_valid=0 at an edge: result, zero, overflow, carry_out and carry_vec hold their previous values; out_valid goes 0.
- Reset (rst=1 at an edge): result=0, carry_vec=0, carry_out=0, overflow=0, out_valid=0, zero=1. rst has priority over in_valid.
- Reset asserted mid-stream discards the operation captured that edge.
- Back-to-back ops: one result per cycle; no stalls, no handshake beyond valid.
- All arithmetic is modulo 2^WIDTH; there are no exceptions. Overflow is a flag only.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, a=3, b=4 -> result=0, zero=1, overflow=0, carry_vec=0, out_valid=0; deassert -> next cycle result=7, out_valid=1.
- SLT: a=2, b=5, ctrl=011 -> result=1, zero=0. Then a=5, b=2 -> result=0, zero=1. Then a=0x80000000, b=1 -> result=1 (signed; subtraction overflows, overflow=1).
- ADD overflow: a=0x7FFFFFFF, b=1, ctrl=000 -> result=0x80000000, overflow=1, carry_out=0. Then a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry_out=1, overflow=0, carry_vec=0xFFFFFFFF.
- SUB: a=5, b=5, ctrl=001 -> result=0, zero=1, carry_out=1, overflow=0. Then a=3, b=5 -> result=0xFFFFFFFE, carry_out=0.
- Logic ops with a=0xF0F0_1234, b=0xFF00_00FF, carry_vec=0 and overflow=0 in every case:
  - XOR -> 0x0FF0_12CB.
  - AND -> 0xF000_0034.
  - NAND -> 0x0FFF_FFCB.
  - NOR -> 0x000F_ED00.
  - OR -> 0xFFF0_12FF.
- Valid gating: one op with in_valid=1 yields result R; then 3 cycles of in_valid=0 with changing a/b/ctrl -> result stays R, out_valid=0. Back-to-back ADD 1+1, SUB 9-4, XOR 6^3 on consecutive cycles -> 2, 5, 5 on consecutive cycles.
